// File: rtl/vga_axil_regfile_slave.sv
// AXI-Lite register-file responder exposing NUM_REGS configuration words to the VGA logic.
// Optional build macro VGA_AXIL_REGFILE_SLAVE_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
//
// state      | meaning
// W_IDLE     | waiting for AW and/or W
// W_HAVE_AW  | address latched, waiting for write data
// W_HAVE_W   | data/strobe latched, waiting for write address
// W_RESP     | write committed, holding B response until bready
// R_IDLE     | waiting for AR
// R_RESP     | read data sampled, holding R response until rready
module vga_axil_regfile_slave #(
  parameter int                       AXIL_ADDR_W = 32,
  parameter int                       AXIL_DATA_W = 32,
  parameter int                       NUM_REGS    = 8,
  parameter logic [AXIL_DATA_W-1:0]   RESET_VAL   = '0
) (
  input  logic                            clk,
  input  logic                            arst_n,
  input  logic [AXIL_ADDR_W-1:0]          araddr,
  input  logic                            arvalid,
  output logic                            arready,
  output logic [AXIL_DATA_W-1:0]          rdata,
  output logic [1:0]                      rresp,
  output logic                            rvalid,
  input  logic                            rready,
  input  logic [AXIL_ADDR_W-1:0]          awaddr,
  input  logic                            awvalid,
  output logic                            awready,
  input  logic [AXIL_DATA_W-1:0]          wdata,
  input  logic [AXIL_DATA_W/8-1:0]        wstrb,
  input  logic                            wvalid,
  output logic                            wready,
  output logic [1:0]                      bresp,
  output logic                            bvalid,
  input  logic                            bready,
  output logic [NUM_REGS*AXIL_DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]             wr_pulse_o
);

  localparam int STRB_W = AXIL_DATA_W / 8;
  localparam int IDX_W  = AXIL_ADDR_W - 2;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef VGA_AXIL_REGFILE_SLAVE_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic [AXIL_ADDR_W-1:0] r_awaddr;
  logic [AXIL_DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0]      r_wstrb;
  logic [AXIL_DATA_W-1:0] r_regs [NUM_REGS];
  logic [1:0]             r_bresp;

  logic                   w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [AXIL_ADDR_W-1:0] w_c_addr;
  logic [AXIL_DATA_W-1:0] w_c_data;
  logic [STRB_W-1:0]      w_c_strb;
  logic [IDX_W-1:0]       w_c_idx, w_ar_idx;
  logic                   w_c_in_range, w_ar_in_range;
  logic [AXIL_DATA_W-1:0] w_rd_val;
  logic                   w_unused;

  // Handshake readiness is decoded from registered state only, never from inputs.
  assign awready = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_W);
  assign wready  = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_AW);
  assign bvalid  = (r_wstate == W_RESP);
  assign bresp   = r_bresp;
  assign arready = (r_rstate == R_IDLE);
  assign rvalid  = (r_rstate == R_RESP);

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;
  assign w_ar_hs = arvalid && arready;

  assign w_c_addr      = (r_wstate == W_HAVE_AW) ? r_awaddr : awaddr;
  assign w_c_data      = (r_wstate == W_HAVE_W) ? r_wdata : wdata;
  assign w_c_strb      = (r_wstate == W_HAVE_W) ? r_wstrb : wstrb;
  assign w_c_idx       = w_c_addr[AXIL_ADDR_W-1:2];
  assign w_c_in_range  = w_c_idx < IDX_W'(NUM_REGS);
  assign w_ar_idx      = araddr[AXIL_ADDR_W-1:2];
  assign w_ar_in_range = w_ar_idx < IDX_W'(NUM_REGS);
  assign w_unused      = ^{w_c_addr[1:0], araddr[1:0]};

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end else if (w_aw_hs) begin
          w_wstate_nxt = W_HAVE_AW;
        end else if (w_w_hs) begin
          w_wstate_nxt = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_w_hs) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (w_aw_hs) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (arvalid) w_rstate_nxt = R_RESP;
      R_RESP:  if (rready)  w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Out-of-range indices match no register, so they read back as zero.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == IDX_W'(i)) w_rd_val = r_regs[i];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RESP_OKAY;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
      if (w_aw_hs) r_awaddr <= awaddr;
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_commit) r_bresp <= w_c_in_range ? RESP_OKAY : RESP_OOR;
      if (w_ar_hs) begin
        rdata <= w_rd_val;
        rresp <= w_ar_in_range ? RESP_OKAY : RESP_OOR;
      end
    end
  end

  // A read sampled on the commit edge sees the pre-write value through non-blocking update.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (w_commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_c_idx == IDX_W'(i)) begin
            for (int k = 0; k < STRB_W; k++) begin
              if (w_c_strb[k]) r_regs[i][8*k +: 8] <= w_c_data[8*k +: 8];
            end
            if (|w_c_strb) wr_pulse_o[i] <= 1'b1;
          end
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign regs_o[g*AXIL_DATA_W +: AXIL_DATA_W] = r_regs[g];
    end
  endgenerate

endmodule

// File: tb/tb_vga_axil_regfile_slave.sv
// Scoreboard bench for vga_axil_regfile_slave: expected B/R responses are queued at issue
// and compared when the DUT completes the handshake.
module tb_vga_axil_regfile_slave;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam logic [31:0] RST_VAL = 32'hC0FF_EE00;
`ifdef VGA_AXIL_REGFILE_SLAVE_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic [AW-1:0] araddr = '0, awaddr = '0;
  logic arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic arready, rvalid, awready, wready, bvalid;
  logic [DW-1:0] rdata;
  logic [1:0] rresp, bresp;
  logic [NR*DW-1:0] regs_o;
  logic [NR-1:0] wr_pulse_o;

  vga_axil_regfile_slave #(.AXIL_ADDR_W(AW), .AXIL_DATA_W(DW), .NUM_REGS(NR), .RESET_VAL(RST_VAL)) dut (
    .clk(clk), .arst_n(arst_n),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  logic [1:0]  b_q [$];
  rexp_t       r_q [$];
  logic [31:0] model [NR];
  int n_checks = 0;
  int n_fail = 0;
  int pulse_exp = 0;
  int pulse_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (arst_n) pulse_seen += $countones(wr_pulse_o);

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) chk(tag, regs_o[i*DW +: DW], model[i]);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, committed = 0, just_c = 0, done = 0;
    bit aw_hs, w_hs, b_hs;
    int bwait = 0;
    int idx = int'(addr[31:2]);
    bit in_rng = (idx < NR);
    logic [7:0] exp_mask = '0;
    if (in_rng && strb != 4'b0) begin
      exp_mask[idx] = 1'b1;
      pulse_exp++;
    end
    if (in_rng)
      for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
    b_q.push_back(in_rng ? 2'b00 : OOR);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      awaddr  = addr; wdata = data; wstrb = strb;
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      if (just_c) begin
        chk("b_latency", {31'b0, bvalid}, 32'd1);
        chk("wr_pulse", {24'b0, wr_pulse_o}, {24'b0, exp_mask});
        just_c = 0;
      end
      if (aw_done && !w_done) chk("awready_have_aw", {31'b0, awready}, 32'd0);
      if (w_done && !aw_done) chk("wready_have_w", {31'b0, wready}, 32'd0);
      bready = 1'b0;
      if (bvalid) begin
        chk("aw_w_ready_in_resp", {30'b0, awready, wready}, 32'd0);
        bready = (bwait >= b_dly);
        if (!bready) chk("bresp_hold", {30'b0, bresp}, {30'b0, b_q[0]});
        bwait++;
      end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      if (b_hs) chk("bresp", {30'b0, bresp}, {30'b0, b_q.pop_front()});
      @(posedge clk);
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      if (aw_done && w_done && !committed) begin committed = 1; just_c = 1; end
      if (b_hs) begin done = 1; break; end
    end
    chk("write_done", {31'b0, done}, 32'd1);
    @(negedge clk);
    awvalid = 0; wvalid = 0; bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_dly, input logic [31:0] exp_data);
    bit ar_done = 0, just_ar = 0, done = 0, ar_hs, r_hs;
    int rwait = 0;
    rexp_t e;
    e.data = exp_data;
    e.resp = (int'(addr[31:2]) < NR) ? 2'b00 : OOR;
    r_q.push_back(e);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      araddr  = addr;
      arvalid = !ar_done;
      if (just_ar) begin
        chk("r_latency", {31'b0, rvalid}, 32'd1);
        just_ar = 0;
      end
      rready = 1'b0;
      if (rvalid) begin
        chk("arready_in_resp", {31'b0, arready}, 32'd0);
        rready = (rwait >= r_dly);
        if (!rready) chk("rdata_hold", rdata, r_q[0].data);
        rwait++;
      end
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      if (r_hs) begin
        e = r_q.pop_front();
        chk("rdata", rdata, e.data);
        chk("rresp", {30'b0, rresp}, {30'b0, e.resp});
      end
      @(posedge clk);
      if (ar_hs) begin ar_done = 1; just_ar = 1; end
      if (r_hs) begin done = 1; break; end
    end
    chk("read_done", {31'b0, done}, 32'd1);
    @(negedge clk);
    arvalid = 0; rready = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] addr);
    int idx = int'(addr[31:2]);
    return (idx < NR) ? model[idx] : 32'h0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old;
    for (int i = 0; i < NR; i++) model[i] = RST_VAL;
    repeat (3) @(negedge clk);
    chk("rst_ready", {29'b0, arready, awready, wready}, 32'd7);
    chk("rst_valid", {30'b0, rvalid, bvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_resp", {28'b0, rresp, bresp}, 32'd0);
    chk("rst_pulse", {24'b0, wr_pulse_o}, 32'd0);
    check_regs("rst_regs");
    arst_n = 1'b1;

    for (int i = 0; i < NR; i++) axi_read(32'(4*i), i % 3, exp_rd(32'(4*i)));

    axi_write(32'h8, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0);
    chk("reg2_full", regs_o[2*DW +: DW], 32'hDEAD_BEEF);
    axi_read(32'h8, 0, exp_rd(32'h8));

    axi_write(32'h8, 32'h1122_3344, 4'b0101, 0, 0, 1);
    chk("reg2_strb", regs_o[2*DW +: DW], 32'hDE22_BE44);
    axi_read(32'hA, 1, exp_rd(32'h8));

    axi_write(32'hC, 32'h0BAD_F00D, 4'b1111, 0, 3, 5);
    axi_write(32'h10, 32'h1357_9BDF, 4'b1100, 3, 0, 5);
    axi_write(32'h1C, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0);
    check_regs("regs_after_writes");
    axi_read(32'hC, 0, exp_rd(32'hC));
    axi_read(32'h10, 2, exp_rd(32'h10));

    axi_write(32'h20, 32'hFFFF_FFFF, 4'b1111, 0, 0, 2);
    check_regs("regs_after_oor");
    axi_read(32'h20, 0, 32'h0);

    old = model[1];
    fork
      axi_write(32'h4, 32'hA5A5_A5A5, 4'b1111, 0, 0, 0);
      axi_read(32'h4, 0, old);
    join
    axi_read(32'h4, 0, 32'hA5A5_A5A5);

    @(negedge clk);
    araddr = 32'h8; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("rvalid_pre_reset", {31'b0, rvalid}, 32'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("rvalid_in_reset", {31'b0, rvalid}, 32'd0);
    chk("ready_in_reset", {29'b0, arready, awready, wready}, 32'd7);
    for (int i = 0; i < NR; i++) model[i] = RST_VAL;
    check_regs("regs_in_reset");
    @(negedge clk);
    arst_n = 1'b1;
    axi_read(32'h4, 0, exp_rd(32'h4));

    repeat (2) @(negedge clk);
    chk("pulse_count", 32'(pulse_seen), 32'(pulse_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
